// File: rtl/mux_n_to_1_rr.sv
// N-channel registered mux with valid/ready, fixed-select or round-robin grant.
// Define MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_n_to_1_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SW-1:0]             sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_ch,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_ch;
  logic [SW-1:0]    r_ptr;

  logic             w_free;
  logic             w_xfer;
  logic             w_adv;
  logic             w_gnt_ok;
  logic             w_gvalid;
  logic             w_rr_ok;
  logic [SW-1:0]    w_rr_gnt;
  logic [SW-1:0]    w_gnt;
  logic [SW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] w_data;

`ifdef MUX_LOCK_EN
  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_lock_ch;
  logic          r_last;
  logic          w_last;
`else
  logic          w_unused;
  assign w_unused = ^in_last;
`endif

  assign w_free = !r_valid || out_ready;

  // Descending scan so the smallest offset from r_ptr wins.
  always_comb begin
    w_rr_ok  = 1'b0;
    w_rr_gnt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_valid[c] && c == (int'(r_ptr) + i) % CHANNELS) begin
          w_rr_ok  = 1'b1;
          w_rr_gnt = SW'(c);
        end
      end
    end
  end

  always_comb begin
    w_gnt    = sel;
    w_gnt_ok = int'(sel) < CHANNELS;
    if (mode) begin
      w_gnt    = w_rr_gnt;
      w_gnt_ok = w_rr_ok;
    end
`ifdef MUX_LOCK_EN
    if (r_state == S_LOCKED) begin
      w_gnt    = r_lock_ch;
      w_gnt_ok = 1'b1;
    end
`endif
  end

  always_comb begin
    w_data   = '0;
    w_gvalid = 1'b0;
`ifdef MUX_LOCK_EN
    w_last   = 1'b0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_gnt == SW'(c)) begin
        w_data   = in_data[c*WIDTH +: WIDTH];
        w_gvalid = in_valid[c];
`ifdef MUX_LOCK_EN
        w_last   = in_last[c];
`endif
      end
    end
  end

  assign w_xfer = !rst && w_free && w_gnt_ok && w_gvalid;

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready[c] = w_xfer && (w_gnt == SW'(c));
    end
  end

  assign w_ptr_nxt = (int'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + 1'b1;

`ifdef MUX_LOCK_EN
  assign w_adv = w_xfer && mode && w_last;
`else
  assign w_adv = w_xfer && mode;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_ch    <= w_gnt;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_adv) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

`ifdef MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_last <= w_last;
      end
      if (w_xfer && r_state == S_IDLE) begin
        r_lock_ch <= w_gnt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_xfer && !w_last) w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_xfer && w_last)  w_state_nxt = S_IDLE;
    endcase
  end

  assign out_last = r_last;
`else
  assign out_last = 1'b0;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Directed bench for mux_n_to_1_rr: fixed, round-robin, backpressure,
// reset mid-stream and packet handling.
module tb_mux_n_to_1_rr;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  mux_n_to_1_rr #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rr_exp [6];
    int sp_exp [4];
    int lk_ch  [4];
    int lk_lst [4];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    sp_exp = '{3, 1, 3, 1};
`ifdef MUX_LOCK_EN
    lk_ch  = '{0, 0, 0, 1};
    lk_lst = '{0, 0, 1, 1};
`else
    lk_ch  = '{0, 1, 0, 1};
    lk_lst = '{0, 0, 0, 0};
`endif

    rst       = 1'b1;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = '0;
    in_last   = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 4'b1111;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_ch",    32'(out_ch),    0);
    chk("rst_last",  32'(out_last),  0);
    chk("rst_ready", 32'(in_ready),  0);

    // Fixed select on channel 2
    tick();
    rst  = 1'b0;
    sel  = 2'd2;
    #1;
    chk("fix_ready0", 32'(in_ready), 32'h4);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("fix_valid", 32'(out_valid), 1);
      chk("fix_data",  32'(out_data),  32'hA2);
      chk("fix_ch",    32'(out_ch),    2);
      chk("fix_ready", 32'(in_ready),  32'h4);
    end

    // Round-robin, all valid; ptr is still 0
    mode = 1'b1;
    #1;
    chk("rr_ready0", 32'(in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_ch",    32'(out_ch),    32'(rr_exp[k]));
      chk("rr_data",  32'(out_data),  32'hA0 + 32'(rr_exp[k]));
    end
    in_valid = '0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_ch",    32'(out_ch),    1);
    chk("drain_data",  32'(out_data),  32'hA1);

    // Sparse round-robin from ptr=2
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sp_ch",   32'(out_ch),   32'(sp_exp[k]));
      chk("sp_data", 32'(out_data), 32'hA0 + 32'(sp_exp[k]));
    end
    in_valid = '0;
    tick();
    chk("sp_drain", 32'(out_valid), 0);

    // Backpressure: ch1 beat, then ch3 waits behind a stalled output
    in_valid = 4'b0010;
    #1;
    chk("bp_ready0", 32'(in_ready), 32'h2);
    tick();
    chk("bp_ch0", 32'(out_ch), 1);
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    #1;
    chk("bp_ready_stall", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ch",    32'(out_ch),    1);
      chk("bp_data",  32'(out_data),  32'hA1);
      chk("bp_ready", 32'(in_ready),  0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_resume", 32'(in_ready), 32'h8);
    tick();
    chk("bp_ch1",   32'(out_ch),   3);
    chk("bp_data1", 32'(out_data), 32'hA3);
    in_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // Reset mid-stream after moving ptr to 2
    in_valid = 4'b0010;
    tick();
    chk("mr_pre_ch", 32'(out_ch), 1);
    rst      = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("mr_ready", 32'(in_ready), 0);
    tick();
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_ch",    32'(out_ch),    0);
    chk("mr_data",  32'(out_data),  0);
    rst = 1'b0;
    tick();
    chk("mr_first", 32'(out_ch), 0);
    tick();
    chk("mr_second", 32'(out_ch), 1);
    in_valid = '0;
    tick();
    in_valid = 4'b1000;
    tick();
    chk("pk_pre_ch", 32'(out_ch), 3);

    // Packet on ch0 (last on its third beat) while ch1 has a single beat
    in_valid = 4'b0011;
    in_last  = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pk_ch",   32'(out_ch),   32'(lk_ch[k]));
      chk("pk_last", 32'(out_last), 32'(lk_lst[k]));
      if (k == 1) in_last = 4'b0011;
    end
    in_valid = '0;
    tick();
    chk("pk_drain", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_to_1_rr.md
# mux_n_to_1_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the 2:1 combinational select used in the adder/subtractor datapath. It supports two modes: fixed select, steered by `sel`, and round-robin arbitration among valid channels. A one-entry output register sustains one transfer per cycle, and the output carries the index of the winning channel. It sits between multiple operand/result producers and a single downstream consumer.

## Interface
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of input channels, 2..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_last`  in  CHANNELS  per-channel end-of-packet. Used only with `MUX_LOCK_EN`.
- `in_ready`  out  CHANNELS  per-channel ready. At most one bit is high in any cycle.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  clog2(CHANNELS)  channel index used in fixed mode.
- `out_data`  out  WIDTH  registered data.
- `out_ch`  out  clog2(CHANNELS)  registered index of the source channel.
- `out_last`  out  1  registered copy of the granted `in_last`. Forced to 0 without `MUX_LOCK_EN`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- **Output register free:** `free = !out_valid || out_ready`.
- **Grant, fixed mode:** grant = `sel`. If `sel >= CHANNELS`, there is no grant.
- **Grant, round-robin mode:** grant = first valid channel at or after `ptr`, searching upward with wrap from CHANNELS-1 to 0. `ptr` is a clog2(CHANNELS)-bit register.
- **Ready:** `in_ready[g] = free && in_valid[g]` for the granted channel g. All other ready bits are 0.
- **Transfer:** a transfer on channel g happens when `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data` ← channel g data.
  - `out_ch` ← g.
  - `out_valid` ← 1.
  - `ptr` ← (g+1) mod CHANNELS, in round-robin mode only.
- **Drain:** on `out_valid && out_ready` with no new transfer, `out_valid` ← 0. `out_data` and `out_ch` hold their values.
- **No valid input:** `ptr` does not move.
- **Mode change:** takes effect at the next arbitration. The pending output beat is unaffected.
- **Producer rule:** a producer must hold `in_data` stable while valid and not ready. The block does not check this.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_ch`=0, `out_last`=0, `ptr`=0, lock state IDLE.
- **During reset:** `in_ready` is all-zero while `rst` is high. A reset mid-packet discards the output beat and the lock.
- **Latency:** 1 cycle from input transfer to `out_valid`.
- **Throughput:** 1 beat/cycle with `out_ready` held high.
- **Combinational path:** `in_ready` depends on `out_ready` in the same cycle. There is no skid buffer.
- **Backpressure:** while `out_valid && !out_ready`, all `in_ready` bits are 0 and the output holds its values.
- **Round-robin fairness:** with N channels continuously valid, each is granted exactly once in every N consecutive transfers.

## Configuration
- **`MUX_LOCK_EN` defined:** packet lock. A 2-state FSM with states IDLE and LOCKED.
  - IDLE → LOCKED on a transfer with `in_last[g]`=0. The locked channel is latched.
  - While LOCKED, the grant is forced to the locked channel regardless of `mode`, `sel` or other valids.
  - LOCKED → IDLE on a transfer with `in_last`=1 from the locked channel.
  - `ptr` advances only on the transfer that ends the packet.
  - `out_last` mirrors the accepted `in_last`.
- **`MUX_LOCK_EN` undefined:** arbitration is per beat. `in_last` is ignored and `out_last` is constant 0. There is no FSM.

## Test plan
- **Fixed mode:** `mode`=0, `sel`=2, all valid, data c = 8'hA0+c, `out_ready`=1 → every cycle `out_data`=8'hA2, `out_ch`=2. Only `in_ready[2]` is high.
- **Round-robin:** `mode`=1, all 4 channels valid continuously → `out_ch` sequence 0,1,2,3,0,1… with one beat per cycle.
- **Sparse round-robin:** valid only on ch1 and ch3, `ptr`=2 → grants 3,1,3,1.
- **Backpressure:** `out_ready`=0 for 3 cycles after one beat → `out_data` holds, `in_ready`=0. When `out_ready` returns to 1, the next beat appears 1 cycle later with no loss or duplication.
- **Reset mid-stream:** assert `rst` for 1 cycle while `out_valid`=1 → `out_valid`=0, `out_ch`=0, and the next round-robin grant starts at ch0.
- **Packet lock (`MUX_LOCK_EN`):** ch0 sends a 3-beat packet (`last` on beat 3) while ch1 is valid → `out_ch`=0,0,0,1. Without the macro the result is 0,1,0,1.
